int_ctrl: RTL and testbench

Parametrised vectored interrupt controller for the CPU's hardware-interrupt path. It sits between the peripheral interrupt lines and the control unit's single `hwint` input. It latches up to NUM_IRQ level- or edge-triggered requests and applies per-channel enables and fixed priority, where the lowest index has the highest priority. It presents one request at a time with a stable vector, and tracks in-service channels until software signals end-of-interrupt. The control unit still applies its own `imask` gating; this block only selects and holds the request.

---
 rtl/int_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_int_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//
// Vectored interrupt controller that sits between the peripheral interrupt
// lines and the control unit's single hwint input. It latches level- or
// edge-triggered requests, applies per-channel enables and a fixed priority
// (lowest index wins), and presents one request at a time with a stable
// vector. Channels stay marked in-service until software issues eoi.
//
// Optional feature macro: INT_CTRL_NESTING_EN
//   defined     : a higher-priority channel may interrupt an in-service
//                 lower-priority one; in_service may hold several bits.
//   not defined : nothing new is presented while any channel is in service.
//
// Parameters
//   NUM_IRQ   number of channels (2..32)
//   VEC_BASE  vector of channel 0; channel i uses VEC_BASE + i
//   ID_W      width of the channel id
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous, active-high reset
//   irq        in   raw requests, synchronous to clk
//   cfg_wr     in   configuration write strobe
//   cfg_sel    in   0 enable, 1 edge mode, 2 pending (W1C), 3 in-service (RO)
//   cfg_wdata  in   configuration write data
//   cfg_rdata  out  combinational read of the register picked by cfg_sel
//   hwint      out  request to the control unit
//   int_ack    in   one-cycle accept pulse from the control unit
//   vector     out  VEC_BASE + int_id while hwint=1, else 0
//   int_id     out  latched channel id while hwint=1, else 0
//   eoi        in   end-of-interrupt pulse from software
//   dbg_state  out  FSM state (0 = IDLE, 1 = REQ)
//
// Handshake: hwint rises once a channel is latched and stays high, with
// vector/int_id frozen, until int_ack is sampled high on a rising edge.
// int_ack seen while hwint is low has no effect. The request is never
// withdrawn once raised.
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter int          NUM_IRQ  = 8,
    parameter logic [31:0] VEC_BASE = 32'h10,
    parameter int          ID_W     = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_wr,
    input  logic [1:0]         cfg_sel,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    output logic [NUM_IRQ-1:0] cfg_rdata,
    output logic               hwint,
    input  logic               int_ack,
    output logic [31:0]        vector,
    output logic [ID_W-1:0]    int_id,
    input  logic               eoi,
    output logic               dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] SEL_ENABLE  = 2'd0;
    localparam logic [1:0] SEL_EDGE    = 2'd1;
    localparam logic [1:0] SEL_PENDING = 2'd2;
    localparam logic [1:0] SEL_INSERV  = 2'd3;

    // Configuration and status registers
    logic [NUM_IRQ-1:0] enable_r;
    logic [NUM_IRQ-1:0] edge_mode_r;
    logic [NUM_IRQ-1:0] pend_r;        // edge-latched requests
    logic [NUM_IRQ-1:0] in_service_r;
    logic [NUM_IRQ-1:0] irq_q;

    // FSM
    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    cur_id_next;

    // Derived terms
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] cur_onehot;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] pend_next;
    logic [NUM_IRQ-1:0] isv_low;
    logic [NUM_IRQ-1:0] isv_next;
    logic [NUM_IRQ-1:0] allowed;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    elig_id;
    logic               elig_any;
    logic               ack_fire;

    // -------------------------------------------------------------------------
    // Pending view
    // -------------------------------------------------------------------------
    assign rise = irq & ~irq_q;

    // Level channels follow the registered input directly; edge channels use
    // the sticky latch. Switching a channel's mode therefore switches its
    // source of truth on the cycle after the write.
    assign pending = (edge_mode_r & pend_r) | (~edge_mode_r & irq_q);

    assign ack_fire   = (state == REQ) && int_ack;
    assign cur_onehot = ONE << cur_id;

    assign w1c_mask = (cfg_wr && (cfg_sel == SEL_PENDING)) ? cfg_wdata : '0;
    assign pend_clr = w1c_mask | (ack_fire ? cur_onehot : '0);

    // A fresh rising edge overrides a clear arriving in the same cycle.
    assign pend_next = rise | (pend_r & ~pend_clr);

    // -------------------------------------------------------------------------
    // In-service bookkeeping
    // -------------------------------------------------------------------------
    // Two's-complement trick isolates the lowest set bit (zero when empty).
    assign isv_low = in_service_r & (~in_service_r + ONE);

    // eoi works on the pre-ack contents, then the ack adds the current channel.
    assign isv_next = (in_service_r & ~(eoi ? isv_low : '0))
                    | (ack_fire ? cur_onehot : '0);

`ifdef INT_CTRL_NESTING_EN
    // Bits strictly below the lowest in-service channel. With nothing in
    // service isv_low is zero and the subtraction wraps to all ones.
    assign allowed = isv_low - ONE;
`else
    assign allowed = (in_service_r == '0) ? '1 : '0;
`endif

    assign eligible = pending & enable_r & ~in_service_r & allowed;
    assign elig_any = |eligible;

    // Priority encoder: scan downwards so the lowest index is written last.
    always_comb begin
        elig_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                elig_id = ID_W'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_r     <= '0;
            edge_mode_r  <= '0;
            pend_r       <= '0;
            in_service_r <= '0;
            irq_q        <= '0;
        end else begin
            irq_q        <= irq;
            pend_r       <= pend_next;
            in_service_r <= isv_next;
            if (cfg_wr && (cfg_sel == SEL_ENABLE)) begin
                enable_r <= cfg_wdata;
            end
            if (cfg_wr && (cfg_sel == SEL_EDGE)) begin
                edge_mode_r <= cfg_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur_id <= '0;
        end else begin
            state  <= state_next;
            cur_id <= cur_id_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // cur_id is only loaded on the IDLE->REQ transition, so enable/edge
    // writes or new arrivals cannot disturb a request already presented.
    always_comb begin
        state_next  = state;
        cur_id_next = cur_id;
        case (state)
            IDLE: begin
                if (elig_any) begin
                    state_next  = REQ;
                    cur_id_next = elig_id;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        hwint     = 1'b0;
        vector    = '0;
        int_id    = '0;
        dbg_state = state;
        if (state == REQ) begin
            hwint  = 1'b1;
            vector = VEC_BASE + 32'(cur_id);
            int_id = cur_id;
        end
    end

    // -------------------------------------------------------------------------
    // Configuration read-back
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_rdata = '0;
        case (cfg_sel)
            SEL_ENABLE:  cfg_rdata = enable_r;
            SEL_EDGE:    cfg_rdata = edge_mode_r;
            SEL_PENDING: cfg_rdata = pending;
            SEL_INSERV:  cfg_rdata = in_service_r;
            default:     cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
//
// Directed scenarios followed by a randomized run against a cycle-level
// reference model of the controller's rules (pending, priority, in-service,
// request hold). Summary line reports passed/total.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq;
    logic         cfg_wr;
    logic [1:0]   cfg_sel;
    logic [N-1:0] cfg_wdata;
    logic [N-1:0] cfg_rdata;
    logic         hwint;
    logic         int_ack;
    logic [31:0]  vector;
    logic [2:0]   int_id;
    logic         eoi;
    logic         dbg_state;

    int n_pass;
    int n_total;

    // Reference model state
    logic [N-1:0] m_en;
    logic [N-1:0] m_edge;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_isv;
    logic [N-1:0] m_irq_q;
    bit           m_req;
    int           m_id;

    int_ctrl #(
        .NUM_IRQ  (N),
        .VEC_BASE (32'h10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .cfg_wr    (cfg_wr),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .hwint     (hwint),
        .int_ack   (int_ack),
        .vector    (vector),
        .int_id    (int_id),
        .eoi       (eoi),
        .dbg_state (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Reference model helpers
    // -------------------------------------------------------------------------
    function automatic logic [N-1:0] m_pending();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) begin
            p[i] = m_edge[i] ? m_pend[i] : m_irq_q[i];
        end
        return p;
    endfunction

    function automatic bit m_allowed(input int ch);
        int lo;
        lo = N;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_isv[i]) lo = i;
        end
`ifdef INT_CTRL_NESTING_EN
        return (ch < lo);
`else
        return (lo == N);
`endif
    endfunction

    function automatic logic [N-1:0] m_rdata(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_en;
            2'd1:    return m_edge;
            2'd2:    return m_pending();
            default: return m_isv;
        endcase
    endfunction

    task automatic model_clear();
        m_en    = '0;
        m_edge  = '0;
        m_pend  = '0;
        m_isv   = '0;
        m_irq_q = '0;
        m_req   = 0;
        m_id    = 0;
    endtask

    // -------------------------------------------------------------------------
    // Driver: apply one cycle of inputs, advance the model at the clock edge,
    // then settle 1 ns past the edge.
    // -------------------------------------------------------------------------
    task automatic step(input logic [N-1:0] s_irq, input logic s_wr,
                        input logic [1:0] s_sel, input logic [N-1:0] s_wd,
                        input logic s_ack, input logic s_eoi);
        logic [N-1:0] p;
        int           pick;
        bit           af;
        irq       = s_irq;
        cfg_wr    = s_wr;
        cfg_sel   = s_sel;
        cfg_wdata = s_wd;
        int_ack   = s_ack;
        eoi       = s_eoi;
        @(posedge clk);
        // decisions use values from before the edge
        p    = m_pending();
        af   = m_req && s_ack;
        pick = -1;
        if (!m_req) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (p[i] && m_en[i] && !m_isv[i] && m_allowed(i)) pick = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_irq[i] && !m_irq_q[i])
                m_pend[i] = 1'b1;
            else if ((af && m_id == i) || (s_wr && s_sel == 2'd2 && s_wd[i]))
                m_pend[i] = 1'b0;
        end
        if (s_eoi) begin
            for (int i = 0; i < N; i++) begin
                if (m_isv[i]) begin
                    m_isv[i] = 1'b0;
                    break;
                end
            end
        end
        if (af) m_isv[m_id] = 1'b1;
        if (m_req) begin
            if (s_ack) m_req = 0;
        end else if (pick >= 0) begin
            m_req = 1;
            m_id  = pick;
        end
        if (s_wr && s_sel == 2'd0) m_en = s_wd;
        if (s_wr && s_sel == 2'd1) m_edge = s_wd;
        m_irq_q = s_irq;
        #1;
    endtask

    task automatic idle(input logic [N-1:0] s_irq);
        step(s_irq, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] sel, output logic [N-1:0] d);
        cfg_sel = sel;
        #1;
        d = cfg_rdata;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        irq       = '0;
        cfg_wr    = 1'b0;
        cfg_sel   = 2'd0;
        cfg_wdata = '0;
        int_ack   = 1'b0;
        eoi       = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        idle('0);
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic [N-1:0] d;
        do_reset();
        n_total++; if (hwint !== 1'b0) $display("FAIL reset_hwint: got %b want 0", hwint); else n_pass++;
        n_total++; if (vector !== 32'h0) $display("FAIL reset_vector: got %h want 0", vector); else n_pass++;
        n_total++; if (int_id !== 3'd0) $display("FAIL reset_int_id: got %0d want 0", int_id); else n_pass++;
        n_total++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state); else n_pass++;
        for (int s = 0; s < 4; s++) begin
            rd(2'(s), d);
            n_total++;
            if (d !== 8'h00) $display("FAIL reset_reg%0d: got %h want 00", s, d);
            else n_pass++;
        end
    endtask

    task automatic test_edge_basic();
        logic [N-1:0] d;
        do_reset();
        step('0, 1'b1, 2'd0, 8'h01, 1'b0, 1'b0);
        step('0, 1'b1, 2'd1, 8'h01, 1'b0, 1'b0);
        idle(8'h01);
        n_total++; if (hwint !== 1'b0) $display("FAIL edge_latency1: hwint got %b want 0", hwint); else n_pass++;
        idle(8'h00);
        n_total++; if (hwint !== 1'b1) $display("FAIL edge_hwint: got %b want 1", hwint); else n_pass++;
        n_total++; if (vector !== 32'h10) $display("FAIL edge_vector: got %h want 10", vector); else n_pass++;
        n_total++; if (int_id !== 3'd0) $display("FAIL edge_id: got %0d want 0", int_id); else n_pass++;
        step('0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        n_total++; if (hwint !== 1'b0) $display("FAIL edge_ack_drop: hwint got %b want 0", hwint); else n_pass++;
        rd(2'd3, d);
        n_total++; if (d !== 8'h01) $display("FAIL edge_isv: got %h want 01", d); else n_pass++;
        rd(2'd2, d);
        n_total++; if (d !== 8'h00) $display("FAIL edge_pend: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_level_priority();
        do_reset();
        step('0, 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0);
        idle(8'h28);
        idle(8'h28);
        n_total++; if (int_id !== 3'd3) $display("FAIL prio_id: got %0d want 3", int_id); else n_pass++;
        n_total++; if (vector !== 32'h13) $display("FAIL prio_vector: got %h want 13", vector); else n_pass++;
        step(8'h20, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        step(8'h20, 1'b0, 2'd0, '0, 1'b0, 1'b1);
        n_total++; if (hwint !== 1'b0) $display("FAIL prio_after_eoi: hwint got %b want 0", hwint); else n_pass++;
        idle(8'h20);
        n_total++; if (vector !== 32'h15) $display("FAIL prio_next_vector: got %h want 15", vector); else n_pass++;
    endtask

    task automatic test_hold_in_req();
        do_reset();
        step('0, 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0);
        idle(8'h10);
        idle(8'h10);
        idle(8'h12);
        idle(8'h12);
        n_total++; if (vector !== 32'h14) $display("FAIL hold_vector: got %h want 14", vector); else n_pass++;
        step(8'h12, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        n_total++; if (hwint !== 1'b0) $display("FAIL hold_ack: hwint got %b want 0", hwint); else n_pass++;
`ifdef INT_CTRL_NESTING_EN
        idle(8'h12);
        n_total++; if (hwint !== 1'b1) $display("FAIL nest_hwint: got %b want 1", hwint); else n_pass++;
        n_total++; if (vector !== 32'h11) $display("FAIL nest_vector: got %h want 11", vector); else n_pass++;
`else
        for (int k = 0; k < 3; k++) begin
            idle(8'h12);
            n_total++;
            if (hwint !== 1'b0) $display("FAIL nonest_blocked: hwint got %b want 0", hwint);
            else n_pass++;
        end
        step(8'h12, 1'b0, 2'd0, '0, 1'b0, 1'b1);
        idle(8'h12);
        n_total++; if (vector !== 32'h11) $display("FAIL nonest_vector: got %h want 11", vector); else n_pass++;
`endif
    endtask

    task automatic test_w1c_race();
        logic [N-1:0] d;
        do_reset();
        step('0, 1'b1, 2'd0, 8'h04, 1'b0, 1'b0);
        step('0, 1'b1, 2'd1, 8'h04, 1'b0, 1'b0);
        idle(8'h04);
        idle(8'h00);
        step(8'h04, 1'b1, 2'd2, 8'h04, 1'b0, 1'b0);
        rd(2'd2, d);
        n_total++; if (d[2] !== 1'b1) $display("FAIL w1c_set_wins: got %b want 1", d[2]); else n_pass++;
        step(8'h04, 1'b1, 2'd2, 8'h04, 1'b0, 1'b0);
        rd(2'd2, d);
        n_total++; if (d !== 8'h00) $display("FAIL w1c_clear: got %h want 00", d); else n_pass++;
        n_total++; if (vector !== 32'h12) $display("FAIL w1c_req_held: got %h want 12", vector); else n_pass++;
    endtask

    task automatic test_level_drop();
        logic [N-1:0] d;
        do_reset();
        step('0, 1'b1, 2'd0, 8'h40, 1'b0, 1'b0);
        idle(8'h40);
        idle(8'h40);
        n_total++; if (hwint !== 1'b1) $display("FAIL drop_hwint: got %b want 1", hwint); else n_pass++;
        idle(8'h00);
        idle(8'h00);
        n_total++; if (vector !== 32'h16) $display("FAIL drop_vector: got %h want 16", vector); else n_pass++;
        step('0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        rd(2'd2, d);
        n_total++; if (d[6] !== 1'b0) $display("FAIL drop_pend: got %b want 0", d[6]); else n_pass++;
        rd(2'd3, d);
        n_total++; if (d !== 8'h40) $display("FAIL drop_isv: got %h want 40", d); else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        logic [N-1:0] d;
        do_reset();
        step('0, 1'b1, 2'd0, 8'h01, 1'b0, 1'b0);
        idle(8'h01);
        idle(8'h01);
        n_total++; if (hwint !== 1'b1) $display("FAIL rstreq_pre: hwint got %b want 1", hwint); else n_pass++;
        #2 rst = 1'b1;
        #1;
        model_clear();
        n_total++; if (hwint !== 1'b0) $display("FAIL rstreq_hwint: got %b want 0", hwint); else n_pass++;
        n_total++; if (vector !== 32'h0) $display("FAIL rstreq_vector: got %h want 0", vector); else n_pass++;
        rd(2'd3, d);
        n_total++; if (d !== 8'h00) $display("FAIL rstreq_isv: got %h want 00", d); else n_pass++;
        rd(2'd2, d);
        n_total++; if (d !== 8'h00) $display("FAIL rstreq_pend: got %h want 00", d); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        step(8'h01, 1'b0, 2'd0, '0, 1'b0, 1'b1);
        step(8'h01, 1'b0, 2'd0, '0, 1'b1, 1'b0);
        n_total++; if (hwint !== 1'b0) $display("FAIL rstreq_post_hwint: got %b want 0", hwint); else n_pass++;
        rd(2'd3, d);
        n_total++; if (d !== 8'h00) $display("FAIL rstreq_post_isv: got %h want 00", d); else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] cur_irq;
        logic         wr;
        logic [1:0]   sel;
        logic [N-1:0] wd;
        logic         ack;
        logic         e;
        do_reset();
        cur_irq = '0;
        step('0, 1'b1, 2'd0, 8'hFF, 1'b0, 1'b0);
        step('0, 1'b1, 2'd1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            cur_irq = cur_irq ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255))
                                 & 8'($urandom_range(0, 255)));
            wr  = ($urandom_range(0, 9) == 0);
            sel = 2'($urandom_range(0, 3));
            wd  = (sel == 2'd0) ? (8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255)))
                                : 8'($urandom_range(0, 255));
            ack = hwint ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            e   = ($urandom_range(0, 5) == 0);
            step(cur_irq, wr, sel, wd, ack, e);
            n_total++;
            if (hwint !== m_req) $display("FAIL rnd_hwint[%0d]: got %b want %b", k, hwint, m_req);
            else n_pass++;
            n_total++;
            if (vector !== (m_req ? 32'h10 + 32'(m_id) : 32'h0))
                $display("FAIL rnd_vector[%0d]: got %h want %h", k, vector,
                         m_req ? 32'h10 + 32'(m_id) : 32'h0);
            else n_pass++;
            n_total++;
            if (int_id !== (m_req ? 3'(m_id) : 3'd0))
                $display("FAIL rnd_id[%0d]: got %0d want %0d", k, int_id, m_req ? m_id : 0);
            else n_pass++;
            n_total++;
            if (cfg_rdata !== m_rdata(sel))
                $display("FAIL rnd_rdata[%0d] sel %0d: got %h want %h", k, sel, cfg_rdata, m_rdata(sel));
            else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        model_clear();
        test_reset();
        test_edge_basic();
        test_level_priority();
        test_hold_in_req();
        test_w1c_race();
        test_level_drop();
        test_reset_mid_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
